// File: rtl/mem_bank.sv
// ============================================================================
// Module      : mem_bank
// Description : Byte-enabled single-port word memory with a post-reset clear
//               sweep and a registered read port. Define MEM_BANK_FWD_EN to
//               return the newly merged word on a same-address read/write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int                c_NBYTES   = DATA_W / 8;
    localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST     = ADDR_W'(DEPTH - 1);
    localparam logic [0:0]        c_ST_CLEAR = 1'b0;
    localparam logic [0:0]        c_ST_READY = 1'b1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;
    logic              r_err;

    logic              w_ready;
    logic              w_in_range;
    logic              w_wr;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd_data;

    assign w_ready    = (r_state == c_ST_READY);
    assign w_in_range = ({1'b0, addr} < c_DEPTH);
    assign w_old      = w_in_range ? r_mem[addr] : '0;
    // The rst cycle itself must not commit a write, even if the FSM is READY.
    assign w_wr       = w_ready & w_en & w_in_range & ~rst;

    for (genvar i = 0; i < c_NBYTES; i++) begin : g_merge
        assign w_merged[8*i +: 8] = be[i] ? data_in[8*i +: 8] : w_old[8*i +: 8];
    end

`ifdef MEM_BANK_FWD_EN
    assign w_rd_data = w_en ? w_merged : w_old;
`else
    assign w_rd_data = w_old;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == c_ST_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_wr) begin
                r_mem[addr] <= w_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_CLEAR;
            r_clr_cnt  <= '0;
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else if (r_state == c_ST_CLEAR) begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            if (r_clr_cnt == c_LAST) begin
                r_state   <= c_ST_READY;
                r_clr_cnt <= '0;
            end else begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end else begin
            r_rd_valid <= rd_en;
            r_err      <= (w_en | rd_en) & ~w_in_range;
            if (rd_en) begin
                r_data_out <= w_in_range ? w_rd_data : '0;
            end
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;
    assign busy     = (r_state == c_ST_CLEAR);

endmodule

`default_nettype wire
